x_uart_tx: RTL



---
 rtl/x_uart_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/x_uart_tx.sv
// 8N1 UART transmitter, LSB first. One byte per valid/ready handshake is framed
// as start bit, eight data bits and one stop bit at CLK_FREQ/BAUD cycles per bit.
module x_uart_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

  if (CYCLES_PER_BIT < 2) begin : g_bad_cfg
    $error("x_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic             tx_nxt;
  logic             bit_end;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      o_tx     <= 1'b1;
      o_ready  <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      o_tx     <= tx_nxt;
      o_ready  <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = 1'b1;
    bit_end   = (baud_cnt == CNT_LAST);

    case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        // o_ready is high exactly in IDLE, so a valid here is an accept.
        if (i_valid) begin
          state_nxt = START;
          shift_nxt = i_data;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end else begin
          baud_nxt = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          // The bit index stops at 7 rather than wrapping back to 0.
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
        end else begin
          baud_nxt = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase

    // Line level is derived from the next state so o_tx can be registered.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule
